// File: rtl/uart_link.sv
// uart_link: parametrised UART transceiver (TX FSM, RX FSM, RX FIFO, runtime loopback).
// Define UART_LINK_PARITY_EN to append an even-parity bit after the data bits.
module uart_link #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   input  logic              rxd_i,
   output logic              txd_o,
   input  logic              loopback_i,
   output logic              frame_err_o,
   output logic              overrun_err_o,
   output logic              parity_err_o
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = $clog2(DATA_W);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

   // ---------------- TX ----------------
   state_e            tx_state_q, tx_state_d;
   logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
   logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic              txd_q, txd_d;
   logic              tx_end;
`ifdef UART_LINK_PARITY_EN
   logic              tx_par_q, tx_par_d;
`endif

   assign tx_end = (tx_cnt_q == BIT_END);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      tx_cnt_d   = (tx_state_q == ST_IDLE || tx_end) ? '0 : tx_cnt_q + CNT_W'(1);
`ifdef UART_LINK_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      case (tx_state_q)
         ST_IDLE: begin
            txd_d = 1'b1;
            if (valid_i) begin
               tx_state_d = ST_START;
               tx_shift_d = data_i;
               txd_d      = 1'b0;
`ifdef UART_LINK_PARITY_EN
               tx_par_d   = ^data_i;
`endif
            end
         end
         ST_START: begin
            if (tx_end) begin
               tx_state_d = ST_DATA;
               tx_bit_d   = '0;
               txd_d      = tx_shift_q[0];
            end
         end
         ST_DATA: begin
            if (tx_end) begin
               if (tx_bit_q == LAST_BIT) begin
`ifdef UART_LINK_PARITY_EN
                  tx_state_d = ST_PARITY;
                  txd_d      = tx_par_q;
`else
                  tx_state_d = ST_STOP;
                  txd_d      = 1'b1;
`endif
               end else begin
                  tx_bit_d   = tx_bit_q + BIT_W'(1);
                  tx_shift_d = tx_shift_q >> 1;
                  txd_d      = tx_shift_d[0];
               end
            end
         end
         ST_PARITY: begin
            if (tx_end) begin
               tx_state_d = ST_STOP;
               txd_d      = 1'b1;
            end
         end
         ST_STOP: begin
            if (tx_end) tx_state_d = ST_IDLE;
         end
         default: begin
            tx_state_d = ST_IDLE;
            txd_d      = 1'b1;
         end
      endcase
   end

   // ---------------- RX ----------------
   state_e            rx_state_q, rx_state_d;
   logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
   logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic              sync1_q, sync1_d, sync2_q, sync2_d;
   logic              lb_q, lb_d;
   logic              rx_end, rx_push;
   logic              frame_err_q, frame_err_d;
`ifdef UART_LINK_PARITY_EN
   logic              rx_par_bad_q, rx_par_bad_d;
   logic              parity_err_q, parity_err_d;
`endif

   assign rx_end = (rx_state_q == ST_START) ? (rx_cnt_q == HALF_END) : (rx_cnt_q == BIT_END);

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_cnt_d    = (rx_state_q == ST_IDLE || rx_end) ? '0 : rx_cnt_q + CNT_W'(1);
      sync1_d     = loopback_i ? txd_q : rxd_i;
      sync2_d     = sync1_q;
      lb_d        = loopback_i;
      rx_push     = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_LINK_PARITY_EN
      rx_par_bad_d = rx_par_bad_q;
      parity_err_d = 1'b0;
`endif
      case (rx_state_q)
         ST_IDLE: begin
            if (!sync2_q) rx_state_d = ST_START;
         end
         ST_START: begin
            if (rx_end) begin
               rx_state_d = sync2_q ? ST_IDLE : ST_DATA;
               rx_bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (rx_end) begin
               rx_shift_d = {sync2_q, rx_shift_q[DATA_W-1:1]};
               rx_bit_d   = rx_bit_q + BIT_W'(1);
               if (rx_bit_q == LAST_BIT) begin
`ifdef UART_LINK_PARITY_EN
                  rx_state_d = ST_PARITY;
`else
                  rx_state_d = ST_STOP;
`endif
               end
            end
         end
         ST_PARITY: begin
            if (rx_end) begin
`ifdef UART_LINK_PARITY_EN
               rx_par_bad_d = sync2_q ^ (^rx_shift_q);
`endif
               rx_state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            // parity verdict is held until the stop sample so both errors pulse together
            if (rx_end) begin
               rx_state_d = ST_IDLE;
`ifdef UART_LINK_PARITY_EN
               parity_err_d = rx_par_bad_q;
               rx_push      = sync2_q && !rx_par_bad_q;
`else
               rx_push      = sync2_q;
`endif
               frame_err_d  = !sync2_q;
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
      if (loopback_i != lb_q) begin
         rx_state_d  = ST_IDLE;
         rx_cnt_d    = '0;
         rx_push     = 1'b0;
         frame_err_d = 1'b0;
         sync1_d     = 1'b1;
         sync2_d     = 1'b1;
`ifdef UART_LINK_PARITY_EN
         parity_err_d = 1'b0;
`endif
      end
   end

   // ---------------- RX FIFO ----------------
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              empty, full, pop, do_push;
   logic              overrun_err_q, overrun_err_d;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop     = !empty && ready_i;
   assign do_push = rx_push && (!full || pop);

   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wr_ptr_q[PTR_W-1:0]] = rx_shift_q;
      wr_ptr_d      = wr_ptr_q + (PTR_W+1)'(do_push);
      rd_ptr_d      = rd_ptr_q + (PTR_W+1)'(pop);
      overrun_err_d = rx_push && full && !pop;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_state_q    <= ST_IDLE;
         tx_cnt_q      <= '0;
         tx_bit_q      <= '0;
         tx_shift_q    <= '0;
         txd_q         <= 1'b1;
         rx_state_q    <= ST_IDLE;
         rx_cnt_q      <= '0;
         rx_bit_q      <= '0;
         rx_shift_q    <= '0;
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         lb_q          <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
         mem_q         <= '{default: '0};
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
`ifdef UART_LINK_PARITY_EN
         tx_par_q      <= 1'b0;
         rx_par_bad_q  <= 1'b0;
         parity_err_q  <= 1'b0;
`endif
      end else begin
         tx_state_q    <= tx_state_d;
         tx_cnt_q      <= tx_cnt_d;
         tx_bit_q      <= tx_bit_d;
         tx_shift_q    <= tx_shift_d;
         txd_q         <= txd_d;
         rx_state_q    <= rx_state_d;
         rx_cnt_q      <= rx_cnt_d;
         rx_bit_q      <= rx_bit_d;
         rx_shift_q    <= rx_shift_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         lb_q          <= lb_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
`ifdef UART_LINK_PARITY_EN
         tx_par_q      <= tx_par_d;
         rx_par_bad_q  <= rx_par_bad_d;
         parity_err_q  <= parity_err_d;
`endif
      end
   end

   assign ready_o       = (tx_state_q == ST_IDLE);
   assign txd_o         = txd_q;
   assign data_o        = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign valid_o       = !empty;
   assign frame_err_o   = frame_err_q;
   assign overrun_err_o = overrun_err_q;
`ifdef UART_LINK_PARITY_EN
   assign parity_err_o  = parity_err_q;
`else
   assign parity_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_link.sv
// Directed self-checking bench for uart_link (DATA_W=8, CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_uart_link;
   localparam int unsigned DW  = 8;
   localparam int unsigned CPB = 4;
   localparam int unsigned FD  = 4;
`ifdef UART_LINK_PARITY_EN
   localparam int unsigned PB  = 1;
`else
   localparam int unsigned PB  = 0;
`endif
   localparam int unsigned NBITS = DW + 2 + PB;
   localparam int unsigned FRAME = NBITS * CPB;
   localparam int unsigned LAT   = FRAME + 4;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic [DW-1:0] data_i;
   logic          valid_i;
   logic          ready_o;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          ready_i;
   logic          rxd_i;
   logic          txd_o;
   logic          loopback_i;
   logic          frame_err_o;
   logic          overrun_err_o;
   logic          parity_err_o;

   uart_link #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .data_i(data_i), .valid_i(valid_i),
      .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
      .rxd_i(rxd_i), .txd_o(txd_o), .loopback_i(loopback_i),
      .frame_err_o(frame_err_o), .overrun_err_o(overrun_err_o),
      .parity_err_o(parity_err_o)
   );

   always #5 clk = ~clk;

   int unsigned   n_checks = 0;
   int unsigned   n_errors = 0;
   int unsigned   cyc = 0;
   logic          txd_log [8192];
   logic [DW-1:0] rx_q [$];
   int unsigned   rx_cyc = 0;
   int unsigned   fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
   int unsigned   fe_cyc = 0, ov_cyc = 0, pe_cyc = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      txd_log[cyc % 8192] = txd_o;
      if (valid_o && ready_i) begin
         rx_q.push_back(data_o);
         rx_cyc = cyc;
      end
      if (frame_err_o)   begin fe_cnt++; fe_cyc = cyc; end
      if (overrun_err_o) begin ov_cnt++; ov_cyc = cyc; end
      if (parity_err_o)  begin pe_cnt++; pe_cyc = cyc; end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [DW-1:0] d, input bit keep, output int unsigned acc);
      data_i  = d;
      valid_i = 1'b1;
      for (int i = 0; i < 3 * LAT && !ready_o; i++) @(negedge clk);
      check("send_ready", ready_o, 1'b1);
      @(posedge clk);
      #1;
      acc = cyc;
      if (!keep) valid_i = 1'b0;
   endtask

   task automatic wait_rx(input int unsigned n, input int unsigned budget, input string tag);
      for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
      check(tag, rx_q.size(), n);
   endtask

   // expected txd for every cycle of a frame starting the cycle after acceptance
   task automatic check_frame(input logic [DW-1:0] d, input int unsigned a, input string tag);
      logic [NBITS-1:0] fb;
      logic [63:0]      got, exp;
`ifdef UART_LINK_PARITY_EN
      fb = {1'b1, ^d, d, 1'b0};
`else
      fb = {1'b1, d, 1'b0};
`endif
      got = '0;
      exp = '0;
      for (int k = 0; k < FRAME; k++) begin
         got[k] = txd_log[(a + k) % 8192];
         exp[k] = fb[k / CPB];
      end
      check(tag, got, exp);
   endtask

   task automatic drive_rx(input logic [DW-1:0] d, input logic stop, input logic par_ok);
      logic [NBITS-1:0] fb;
`ifdef UART_LINK_PARITY_EN
      fb = {stop, (^d) ^ !par_ok, d, 1'b0};
`else
      fb = {stop, d, 1'b0};
      if (par_ok) fb = fb;
`endif
      @(posedge clk);
      #1;
      for (int b = 0; b < NBITS; b++) begin
         rxd_i = fb[b];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rxd_i = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned a0, a1, a2, a;
      int unsigned fe0, pe0, ov0;
      rst_ni = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b1;
      rxd_i = 1'b1; loopback_i = 1'b1;
      #12;
      check("rst_txd",   txd_o, 1'b1);
      check("rst_ready", ready_o, 1'b1);
      check("rst_valid", valid_o, 1'b0);
      check("rst_errs",  {frame_err_o, overrun_err_o, parity_err_o}, 3'b000);
      #11 rst_ni = 1'b1;
      repeat (2) @(negedge clk);

      // loopback single word
      rx_q.delete();
      send(8'hA5, 1'b0, a);
      wait_rx(1, LAT + 8, "t1_rx_count");
      check("t1_data", rx_q[0], 8'hA5);
      check("t1_latency_ok", (rx_cyc - a) <= LAT, 1'b1);
      check_frame(8'hA5, a, "t1_txd_frame");
      check("t1_idle_after", txd_log[(a + FRAME) % 8192], 1'b1);
      check("t1_no_errs", fe_cnt + ov_cnt + pe_cnt, 0);

      // back-to-back with valid_i held
      rx_q.delete();
      send(8'h00, 1'b1, a0);
      send(8'hFF, 1'b1, a1);
      send(8'h3C, 1'b0, a2);
      wait_rx(3, LAT + 8, "t2_rx_count");
      check("t2_gap01", a1 - a0, FRAME + 1);
      check("t2_gap12", a2 - a1, FRAME + 1);
      check("t2_idle_cycle", txd_log[(a1 - 1) % 8192], 1'b1);
      check("t2_start_after_idle", txd_log[a1 % 8192], 1'b0);
      check_frame(8'h00, a0, "t2_frame0");
      check_frame(8'hFF, a1, "t2_frame1");
      check_frame(8'h3C, a2, "t2_frame2");
      check("t2_w0", rx_q[0], 8'h00);
      check("t2_w1", rx_q[1], 8'hFF);
      check("t2_w2", rx_q[2], 8'h3C);

      // overrun
      @(posedge clk); #1 ready_i = 1'b0;
      rx_q.delete();
      ov0 = ov_cnt;
      for (int w = 1; w <= 5; w++) send(DW'(w), 1'b0, a);
      repeat (LAT + 4) @(negedge clk);
      check("t3_overrun_once", ov_cnt - ov0, 1);
      check("t3_overrun_on_w5", (ov_cyc > a) && (ov_cyc <= a + LAT), 1'b1);
      check("t3_valid", valid_o, 1'b1);
      check("t3_head", data_o, 8'h01);
      @(posedge clk); #1 ready_i = 1'b1;
      wait_rx(4, 10, "t3_drain_count");
      for (int i = 0; i < 4; i++) check("t3_drain", rx_q[i], DW'(i + 1));
      repeat (3) @(negedge clk);
      check("t3_empty", valid_o, 1'b0);
      check("t3_no_extra", rx_q.size(), 4);

      // frame error on external line
      @(posedge clk); #1 loopback_i = 1'b0; rxd_i = 1'b1;
      repeat (4) @(posedge clk); #1;
      rx_q.delete();
      fe0 = fe_cnt;
      drive_rx(8'h5A, 1'b0, 1'b1);
      check("t4_frame_err", fe_cnt - fe0, 1);
      check("t4_no_push", rx_q.size(), 0);
      check("t4_valid_low", valid_o, 1'b0);
      drive_rx(8'h5A, 1'b1, 1'b1);
      wait_rx(1, 10, "t4_good_count");
      check("t4_good_data", rx_q[0], 8'h5A);
      check("t4_no_new_err", fe_cnt - fe0, 1);

      // glitch rejection
      rx_q.delete();
      fe0 = fe_cnt; pe0 = pe_cnt;
      @(posedge clk); #1 rxd_i = 1'b0;
      @(posedge clk); #1 rxd_i = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("t5_no_push", rx_q.size(), 0);
      check("t5_no_err", (fe_cnt - fe0) + (pe_cnt - pe0), 0);
      drive_rx(8'hC3, 1'b1, 1'b1);
      wait_rx(1, 10, "t5_after_count");
      check("t5_after_data", rx_q[0], 8'hC3);

`ifdef UART_LINK_PARITY_EN
      // parity errors on external line
      rx_q.delete();
      fe0 = fe_cnt; pe0 = pe_cnt;
      drive_rx(8'h07, 1'b1, 1'b0);
      check("t6_parity_err", pe_cnt - pe0, 1);
      check("t6_no_frame_err", fe_cnt - fe0, 0);
      check("t6_no_push", rx_q.size(), 0);
      drive_rx(8'h07, 1'b0, 1'b0);
      check("t6_both_par", pe_cnt - pe0, 2);
      check("t6_both_frame", fe_cnt - fe0, 1);
      check("t6_same_cycle", pe_cyc, fe_cyc);
      check("t6_still_empty", rx_q.size(), 0);
`endif

      // reset mid-frame with two words buffered
      @(posedge clk); #1 loopback_i = 1'b1; ready_i = 1'b0;
      repeat (4) @(posedge clk); #1;
      send(8'h11, 1'b0, a);
      send(8'h22, 1'b0, a);
      repeat (LAT + 2) @(negedge clk);
      check("t7_pre_valid", valid_o, 1'b1);
      send(8'h33, 1'b0, a);
      while (cyc < a + 13) @(negedge clk);
      check("t7_pre_txd_bit2", txd_o, 1'b0);
      #2 rst_ni = 1'b0;
      #1;
      check("t7_txd_async", txd_o, 1'b1);
      check("t7_valid_async", valid_o, 1'b0);
      #20 rst_ni = 1'b1;
      repeat (3) @(negedge clk);
      check("t7_ready_after", ready_o, 1'b1);
      check("t7_valid_after", valid_o, 1'b0);
      check("t7_txd_after", txd_o, 1'b1);

`ifndef UART_LINK_PARITY_EN
      check("parity_tied_low", pe_cnt, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/uart_link.md
Name: uart_link

Overview:
- Parametrised UART transceiver. Successor to the fixed 8-bit, prescale-1 TX/RX loopback wrapper.
- Self-contained TX and RX state machines, with configurable word width and bit period.
- RX side has a receive FIFO.
- A runtime loopback mode routes TX to RX internally. With loopback off, the block talks to an external serial line.
- Sits between the host-side valid/ready byte stream and the board UART pins.

Parameters:
- DATA_W, 8: data bits per frame; legal range 5..16.
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be an even number, 4 or greater.
- FIFO_DEPTH, 4: RX FIFO entries; must be a power of two, 2 or greater.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- data_i  in  DATA_W  TX word.
- valid_i  in  1  TX word valid.
- ready_o  out  1  TX can accept a word.
- data_o  out  DATA_W  RX FIFO head word.
- valid_o  out  1  RX FIFO not empty.
- ready_i  in  1  consumer pops the RX head.
- rxd_i  in  1  external serial input; asynchronous.
- txd_o  out  1  serial output; idles high.
- loopback_i  in  1  1 = RX source is the internal TX line; 0 = RX source is rxd_i.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_err_o  out  1  one-cycle pulse: received word dropped because the FIFO was full.
- parity_err_o  out  1  one-cycle pulse: parity mismatch.

Behaviour:
- Reset values:
  - txd_o=1, ready_o=1, valid_o=0, all error outputs 0.
  - FIFO empty; both state machines in IDLE.
  - Synchroniser flops reset to 1.
- Reset asserted mid-frame:
  - Frame aborted immediately; txd_o goes high asynchronously.
  - FIFO contents discarded.
- TX FSM states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - ready_o = (state==IDLE). A word is accepted when valid_i && ready_o, and data_i is latched on that edge.
  - Frame timing: start bit 0, then DATA_W bits LSB first, then stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles, driven from the cycle after acceptance.
  - After the stop bit the FSM returns to IDLE. Back-to-back accept is possible on that IDLE cycle, so the gap is exactly one idle-high cycle.
- RX line source:
  - loopback_i=1: the internal TX line. loopback_i=0: rxd_i.
  - The selected line passes through a 2-flop synchroniser.
  - Any change of loopback_i forces RX to IDLE; a partial frame is discarded with no error pulse.
- RX FSM states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a low synchronised line starts a count of CLKS_PER_BIT/2 cycles.
  - At mid start bit, a high line returns to IDLE as a glitch: no error, no push.
  - Otherwise the line is sampled every CLKS_PER_BIT cycles, at bit centres.
  - Stop sample = 1: push the word.
  - Stop sample = 0: pulse frame_err_o and drop the word.
  - After the stop sample, RX returns to IDLE at once and can detect the next start edge.
- FIFO:
  - data_o = head; valid_o = !empty. Pop on valid_o && ready_i.
  - data_o holds stable while valid_o && !ready_i.
  - Push into a full FIFO with no pop that cycle: pulse overrun_err_o and drop the newest word; the FIFO is unchanged.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Push and pop in the same cycle while empty: push only (no fall-through); valid_o rises the next cycle.
- Loopback latency: the word is at the FIFO head no later than (DATA_W+2)*CLKS_PER_BIT + 4 cycles after acceptance. Add CLKS_PER_BIT when PARITY_EN is defined.
- Error outputs are registered single-cycle pulses.

Optional Feature:
- Macro: UART_LINK_PARITY_EN.
- Defined:
  - TX inserts an even-parity bit between the last data bit and the stop bit (XOR of data bits), so the frame is DATA_W+3 bits.
  - RX samples that bit. On mismatch it pulses parity_err_o and drops the word.
  - When the parity and stop checks both fail, both error outputs pulse in the same cycle and the word is dropped.
- Not defined:
  - No parity bit; the frame is DATA_W+2 bits.
  - parity_err_o is tied to 0.

Test Plan:
- Loopback, single word:
  - Setup: CLKS_PER_BIT=4, loopback_i=1, ready_i=1; send 0xA5.
  - Required: txd_o shows bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; valid_o pulses with data_o=0xA5 within the latency bound; no error pulses.
- Loopback, back-to-back:
  - Stimulus: 0x00, 0xFF, 0x3C with valid_i held high.
  - Required: exactly one idle-high cycle between frames; received in order 0x00, 0xFF, 0x3C.
- Overrun:
  - Setup: ready_i=0, FIFO_DEPTH=4; loop back 0x01..0x05.
  - Required: valid_o=1; overrun_err_o pulses once, on word 0x05. Raising ready_i then drains 0x01..0x04.
- Frame error:
  - Setup: loopback_i=0; drive rxd_i with a frame of 0x5A whose stop bit is 0.
  - Required: frame_err_o pulses once; valid_o stays 0. A following good frame of 0x5A is received correctly.
- Glitch rejection:
  - Stimulus: rxd_i low for 1 cycle, then high.
  - Required: RX returns to IDLE; no push, no error.
- Reset mid-frame:
  - Stimulus: assert rst_ni low at the 3rd data bit of a TX frame while the FIFO holds 2 words.
  - Required: txd_o=1 immediately; valid_o=0; ready_o=1 after release.
- Parity (build with UART_LINK_PARITY_EN):
  - Stimulus: send 0x07 on rxd_i with a wrong parity bit.
  - Required: parity_err_o pulses; no push.
